// File: rtl/mac_seq.sv
// Sequential multiply-accumulate over N_TAPS sample/coefficient pairs with valid/ready I/O.
// Define MAC_SEQ_SAT_EN to saturate each add; the default build wraps modulo 2^ACC_W.
module mac_seq #(
  parameter int N_TAPS = 64,
  parameter int ACC_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cwr_en,
  input  logic [$clog2(N_TAPS)-1:0] cwr_addr,
  input  logic [15:0]               cwr_data,
  input  logic                      in_valid,
  input  logic [15:0]               in_data,
  output logic                      in_ready,
  input  logic                      start,
  output logic                      busy,
  output logic [ACC_W-1:0]          out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      done
);

  localparam int AW = $clog2(N_TAPS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t                   r_state, w_state_nxt;
  logic [AW:0]              r_count;
  logic [AW-1:0]            r_index;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_done;
  logic [15:0]              r_coef   [N_TAPS];
  logic [15:0]              r_sample [N_TAPS];

  logic                     w_push, w_start_ok, w_last, w_consume;
  logic signed [15:0]       w_samp_s, w_coef_s;
  logic signed [31:0]       w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext, w_acc_nxt;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    w_push      = 1'b0;
    w_start_ok  = 1'b0;
    w_last      = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready   = (r_count < (AW+1)'(N_TAPS));
        w_push     = in_valid & in_ready;
        // start is judged on the count before this edge, so a push+start at N-1 only pushes
        w_start_ok = start && (r_count == (AW+1)'(N_TAPS));
        if (w_start_ok) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        w_last = (r_index == AW'(N_TAPS-1));
        if (w_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        w_consume = out_ready;
        if (w_consume) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_samp_s   = r_sample[r_index];
  assign w_coef_s   = r_coef[r_index];
  assign w_prod     = 32'(w_samp_s) * 32'(w_coef_s);
  assign w_prod_ext = ACC_W'(w_prod);

`ifdef MAC_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] w_sum_wide;

  assign w_sum_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);

  always_comb begin
    w_acc_nxt = w_sum_wide[ACC_W-1:0];
    if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1])
      w_acc_nxt = w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
  end
`else
  assign w_acc_nxt = r_acc + w_prod_ext;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_index <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_push) r_count <= r_count + (AW+1)'(1);
          if (w_start_ok) begin
            r_acc   <= '0;
            r_index <= '0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_nxt;
          r_index <= r_index + AW'(1);
          if (w_last) r_done <= 1'b1;
        end
        S_HOLD: if (w_consume) r_count <= '0;
        default: ;
      endcase
    end
  end

  // Storage is not reset: coefficients must survive a reset
  always_ff @(posedge clk) begin
    if (!reset && cwr_en && r_state != S_RUN) r_coef[cwr_addr] <= cwr_data;
    if (!reset && w_push) r_sample[r_count[AW-1:0]] <= in_data;
  end

  assign out  = r_acc;
  assign done = r_done;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: directed scenarios plus randomized runs against a sum-of-products model.
module tb_mac_seq;
  localparam int N = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cwr_en = 1'b0;
  logic [5:0]  cwr_addr = '0;
  logic [15:0] cwr_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_coef [N];
  logic [15:0] m_samp [N];

  always #5 clk = ~clk;

  mac_seq #(.N_TAPS(N), .ACC_W(32)) dut (
    .clk(clk), .reset(reset), .cwr_en(cwr_en), .cwr_addr(cwr_addr), .cwr_data(cwr_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .start(start), .busy(busy),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  // Expected result: dot product of the model arrays, clamped per step or wrapped at 32 bits
  function automatic logic [31:0] model_result();
    longint acc = 0;
    logic signed [15:0] sa, sc;
    int a, b;
    for (int i = 0; i < N; i++) begin
      sa = m_samp[i];
      sc = m_coef[i];
      a = sa;
      b = sc;
      acc = acc + longint'(a * b);
`ifdef MAC_SEQ_SAT_EN
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`endif
    end
    return acc[31:0];
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 3))
      0: return 16'h8000;
      1: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coefs();
    for (int i = 0; i < N; i++) begin
      cwr_en = 1'b1; cwr_addr = 6'(i); cwr_data = m_coef[i];
      tick();
    end
    cwr_en = 1'b0;
  endtask

  task automatic fill_samples(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      in_valid = 1'b1; in_data = m_samp[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Pulse start, then wait (bounded) for out_valid; collects latency, done count and busy after start
  task automatic do_run(input bit scribble, output int lat, output int dones, output bit busy1);
    start = 1'b1;
    tick();
    start = 1'b0;
    busy1 = busy;
    lat = 0;
    dones = 0;
    while (!out_valid && lat < 300) begin
      if (scribble && lat < 5) begin
        cwr_en = 1'b1; cwr_addr = 6'($urandom); cwr_data = 16'($urandom);
      end else cwr_en = 1'b0;
      tick();
      lat++;
      if (done) dones++;
    end
    cwr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) dones++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (out !== 32'h0) begin n_err++; $display("FAIL reset_out got %h want 0", out); end
  endtask

  task automatic test_basic();
    int lat, dones; bit b1;
    for (int i = 0; i < N; i++) begin m_coef[i] = 16'h0002; m_samp[i] = 16'h0001; end
    load_coefs();
    fill_samples(0, N-1);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_full_in_ready got %b want 0", in_ready); end
    do_run(1'b0, lat, dones, b1);
    n_vec++; if (lat !== N) begin n_err++; $display("FAIL basic_latency got %0d want %0d", lat, N); end
    n_vec++; if (dones !== 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", dones); end
    n_vec++; if (out !== 32'd128) begin n_err++; $display("FAIL basic_out got %h want %h", out, 32'd128); end
    n_vec++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL basic_hold_flags got busy=%b in_ready=%b want 0 0", busy, in_ready); end
    consume();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL basic_consume got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_negative();
    int lat, dones; bit b1;
    for (int i = 0; i < N; i++) begin m_coef[i] = 16'h0001; m_samp[i] = 16'hFFFF; end
    load_coefs();
    fill_samples(0, N-1);
    do_run(1'b0, lat, dones, b1);
    n_vec++; if (out !== 32'hFFFFFFC0) begin n_err++; $display("FAIL neg_out got %h want FFFFFFC0", out); end
    consume();
  endtask

  task automatic test_hold();
    int lat, dones; bit b1;
    logic [31:0] held;
    for (int i = 0; i < N; i++) begin
      m_coef[i] = (i < 5) ? 16'(i + 1) : 16'h0;
      m_samp[i] = (i < 5) ? 16'(i + 1) : 16'($urandom);
    end
    load_coefs();
    fill_samples(0, N-1);
    do_run(1'b0, lat, dones, b1);
    held = out;
    n_vec++; if (out !== 32'd55) begin n_err++; $display("FAIL hold_out got %h want %h", out, 32'd55); end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_vec++;
      if (out !== 32'd55 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL hold_stable cycle %0d got out=%h valid=%b want %h 1", k, out, out_valid, 32'd55);
      end
    end
    consume();
  endtask

  task automatic test_start_gate();
    int lat, dones; bit b1;
    for (int i = 0; i < N; i++) m_samp[i] = rnd16();
    fill_samples(0, N-2);
    start = 1'b1; tick(); start = 1'b0;
    n_vec++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL gate_early_start got busy=%b in_ready=%b want 0 1", busy, in_ready); end
    in_valid = 1'b1; in_data = m_samp[N-1]; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    n_vec++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL gate_push_start got busy=%b in_ready=%b want 0 0", busy, in_ready); end
    do_run(1'b0, lat, dones, b1);
    n_vec++; if (b1 !== 1'b1) begin n_err++; $display("FAIL gate_busy_after_start got %b want 1", b1); end
    n_vec++; if (out !== model_result()) begin n_err++; $display("FAIL gate_out got %h want %h", out, model_result()); end
    consume();
  endtask

  task automatic test_mid_reset();
    int lat, dones; bit b1;
    for (int i = 0; i < N; i++) m_samp[i] = rnd16();
    fill_samples(0, N-1);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || out !== 32'h0) begin
      n_err++; $display("FAIL midreset_flags got busy=%b ov=%b ir=%b done=%b out=%h want 0 0 1 0 0", busy, out_valid, in_ready, done, out);
    end
    for (int i = 0; i < N; i++) m_samp[i] = rnd16();
    fill_samples(0, N-2);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_count_cleared got in_ready=%b want 1", in_ready); end
    fill_samples(N-1, N-1);
    do_run(1'b0, lat, dones, b1);
    n_vec++; if (out !== model_result()) begin n_err++; $display("FAIL midreset_out got %h want %h", out, model_result()); end
    consume();
  endtask

  task automatic test_saturation();
    int lat, dones; bit b1;
    logic [31:0] want;
`ifdef MAC_SEQ_SAT_EN
    want = 32'h7FFFFFFF;
`else
    want = 32'hFFC00040;
`endif
    for (int i = 0; i < N; i++) begin m_coef[i] = 16'h7FFF; m_samp[i] = 16'h7FFF; end
    load_coefs();
    fill_samples(0, N-1);
    do_run(1'b0, lat, dones, b1);
    n_vec++; if (out !== want) begin n_err++; $display("FAIL sat_out got %h want %h", out, want); end
    consume();
  endtask

  task automatic test_random();
    int lat, dones; bit b1;
    int a;
    for (int i = 0; i < N; i++) m_coef[i] = rnd16();
    load_coefs();
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 4; k++) begin
        a = $urandom_range(0, N-1);
        m_coef[a] = rnd16();
        cwr_en = 1'b1; cwr_addr = 6'(a); cwr_data = m_coef[a];
        tick();
      end
      cwr_en = 1'b0;
      for (int i = 0; i < N; i++) m_samp[i] = rnd16();
      fill_samples(0, N-1);
      do_run(1'b1, lat, dones, b1);
      n_vec++; if (lat !== N) begin n_err++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, N); end
      n_vec++; if (dones !== 1) begin n_err++; $display("FAIL rand%0d_done got %0d want 1", it, dones); end
      n_vec++; if (out !== model_result()) begin n_err++; $display("FAIL rand%0d_out got %h want %h", it, out, model_result()); end
      a = $urandom_range(0, N-1);
      m_coef[a] = rnd16();
      cwr_en = 1'b1; cwr_addr = 6'(a); cwr_data = m_coef[a];
      tick();
      cwr_en = 1'b0;
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_hold();
    test_start_gate();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 The block SHALL have parameter N_TAPS, default 64, meaning the number of sample/coefficient pairs per run (power of 2, 2..64).
REQ-002 The block SHALL have parameter ACC_W, default 32, meaning the accumulator and result width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cwr_en  input  1  coefficient write strobe.
REQ-006 cwr_addr  input  log2(N_TAPS)  coefficient write index.
REQ-007 cwr_data  input  16  coefficient value, signed two's complement.
REQ-008 in_valid  input  1  a sample is offered on in_data.
REQ-009 in_data  input  16  sample value, signed two's complement.
REQ-010 in_ready  output  1  the block accepts a sample this cycle.
REQ-011 start  input  1  request to run one accumulation.
REQ-012 busy  output  1  a run is in progress (RUN state).
REQ-013 out  output  ACC_W  accumulated result.
REQ-014 out_valid  output  1  out holds a result not yet consumed.
REQ-015 out_ready  input  1  the consumer takes the result.
REQ-016 done  output  1  one-cycle pulse when a run completes.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and HOLD, and SHALL enter IDLE on reset.
REQ-018 In IDLE, in_ready SHALL equal (count < N_TAPS); a cycle with in_valid&in_ready SHALL write in_data to sample[count] and increment count.
REQ-019 In IDLE, start SHALL be accepted only when count == N_TAPS at that clock edge; otherwise it SHALL be ignored with no side effect, and a push and start in the same cycle when count == N_TAPS-1 SHALL push only.
REQ-020 Accepting start SHALL clear the accumulator, set index to 0 and enter RUN; in RUN and HOLD, in_ready SHALL be 0.
REQ-021 In RUN, each cycle SHALL add sext(sample[index])*sext(coef[index]), a signed 32-bit product, to the accumulator and increment index.
REQ-022 After the add at index N_TAPS-1, the FSM SHALL enter HOLD with out_valid=1 and a done pulse of exactly one cycle.
REQ-023 Latency: if start is accepted at edge T, out_valid SHALL first be 1 after edge T+N_TAPS.
REQ-024 In HOLD, out SHALL remain stable; out_valid&out_ready SHALL return the FSM to IDLE with count=0 and out_valid=0.
REQ-025 A coefficient write SHALL take effect in IDLE or HOLD and SHALL be ignored in RUN.
REQ-026 The accumulator SHALL wrap modulo 2^ACC_W unless REQ-031 applies.

Reset
REQ-027 Reset SHALL take priority over every other input at any state, including mid-RUN.
REQ-028 Reset values SHALL be: state=IDLE, count=0, index=0, accumulator/out=0, busy=0, out_valid=0, done=0, in_ready=1.
REQ-029 Reset SHALL NOT clear the coefficient memory, and sample contents are don't-care after reset.

Configuration
REQ-030 The macro MAC_SEQ_SAT_EN SHALL select the accumulation mode.
REQ-031 With MAC_SEQ_SAT_EN defined, each add SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and, once saturated, later adds SHALL continue from the clamped value.
REQ-032 Without MAC_SEQ_SAT_EN, each add SHALL wrap per REQ-026 and no saturation logic SHALL exist.

Verification
REQ-033 With coefs all 0x0002, push 64 samples of 0x0001, then start -> out=128, out_valid 64 cycles after start, done pulses once.
REQ-034 With coefs all 0x0001 and samples all 0xFFFF -> out=0xFFFFFFC0 (-64).
REQ-035 With samples[0..4]=1..5, coefs[0..4]=1..5 and the rest 0 -> out=55, and holding out_ready=0 for 10 cycles keeps out and out_valid stable.
REQ-036 Start after only 63 pushes -> ignored, busy stays 0; push the 64th sample and start -> accepted, busy=1 the next cycle.
REQ-037 Assert reset at RUN cycle 10 -> after that edge busy=0, out_valid=0, in_ready=1, count=0; refill the samples and run -> correct result with the retained coefs.
REQ-038 With samples and coefs all 0x7FFF -> out=0x7FFFFFFF when MAC_SEQ_SAT_EN is defined, and out=0xFFC00040 when it is not.
